npc_gen: RTL and testbench
==========================

Name: npc_gen

Overview:
- Next-PC generator for the fetch stage. It is the producer side of the PC register interface: it takes the registered PC back and drives npc into the PC register every cycle.
- It arbitrates between sequential increment, taken branches resolved in EX, and jumps decoded in ID.
- It holds redirects that arrive during a stall until the stall clears.
- It generates IF/ID flush and fetch-valid qualifiers for the downstream pipeline registers.

Parameters:
RESET_VECTOR, 32'h00000000, address driven on npc while reset is asserted; the PC register captures it.
PC_STEP, 4, sequential increment in bytes.
FLUSH_SLOTS, 2, number of unstalled cycles flush_if_id stays high after a redirect is applied (IF and ID slots).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
pc  input  32  current PC from the PC register.
stall  input  1  hazard-unit stall; PC must hold.
br_taken  input  1  EX-stage branch taken strobe.
br_target  input  32  EX-stage branch target.
jump  input  1  ID-stage jump strobe.
jump_target  input  32  ID-stage jump target.
npc  output  32  next PC, consumed by the PC register.
fetch_valid  output  1  current IF instruction is valid.
flush_if_id  output  1  squash the IF/ID register contents.
redirect_pending  output  1  a redirect is held awaiting stall release.
misalign_err  output  1  sticky: a redirect target had nonzero bits [1:0].

Behaviour:
- State is registered, async-cleared by rst:
  - pend_valid, pend_target[31:0]
  - flush_cnt, width $clog2(FLUSH_SLOTS+1)
  - misalign_err
- Reset values: pend_valid=0, pend_target=0, flush_cnt=0, misalign_err=0.
- Outputs during rst: npc=RESET_VECTOR, fetch_valid=0, flush_if_id=0, redirect_pending=0.
- npc is combinational from pc, inputs and state. Zero-cycle latency: the PC register loads it on the next clk edge.
- Target alignment: every redirect target is used with bits [1:0] forced to 2'b00. A nonzero [1:0] on an accepted redirect sets misalign_err at the next edge; it stays set until reset.
- Redirect source priority, highest first: br_taken, then jump. Branch is the older instruction, so branch wins; a simultaneous jump is dropped.
- When stall=0:
  - If pend_valid=1: npc = pend_target. Clear pend_valid. Load flush_cnt = FLUSH_SLOTS.
  - Else if br_taken or jump: npc = aligned target of the winner. Load flush_cnt = FLUSH_SLOTS.
  - Else: npc = pc + PC_STEP, modulo 2^32 (32'hFFFFFFFC -> 32'h00000000). If flush_cnt != 0, decrement it.
  - A pending redirect beats a same-cycle new redirect. The new one is dropped, because it belongs to the squashed path.
- When stall=1:
  - npc = pc (hold). flush_cnt holds.
  - br_taken captures into pend_target and sets pend_valid. It overwrites any pending entry.
  - jump captures only if pend_valid=0.
- Outputs:
  - redirect_pending = pend_valid.
  - flush_if_id = (flush_cnt != 0) or (a redirect applied this cycle).
  - fetch_valid = !rst and !stall and !flush_if_id.
- Reset mid-operation: pending redirect and flush count are discarded immediately. Fetch restarts at RESET_VECTOR.
- No X propagation: target inputs are ignored when their strobe is low.

Decomposition:
- Shared fetch package holds:
  - RESET_VECTOR and PC_STEP defaults
  - the 32-bit address width constant
  - the redirect source encoding (NONE/BRANCH/JUMP), used by the hazard unit and trace monitors
- One natural sub-module: npc_redirect_hold. It contains the pend_valid/pend_target register plus capture and priority logic.
- The flush counter and npc mux stay in the top module.

Test Plan:
- Reset, then release with pc fed back from a modelled PC register.
  - During rst: npc=32'h00000000, fetch_valid=0.
  - After release: PC sequence 0,4,8,C,10 with fetch_valid=1 each cycle.
- br_taken=1, br_target=32'h00000040 at pc=32'h0000000C, no stall.
  - npc=32'h00000040 that cycle.
  - flush_if_id=1 for that cycle plus 2 following cycles.
  - Then PC 40,44.
- Simultaneous br_taken (target 32'h00000080) and jump (target 32'h00000100).
  - npc=32'h00000080; jump ignored.
- stall=1 for 3 cycles; jump to 32'h00000200 in the first stall cycle.
  - npc=pc while stalled.
  - redirect_pending=1.
  - On the first unstalled cycle npc=32'h00000200 and redirect_pending drops.
- Stalled, jump to 32'h00000300 pending, then br_taken to 32'h00000400 while still stalled.
  - After release, npc=32'h00000400.
- pc=32'hFFFFFFFC with no redirect gives npc=32'h00000000.
- br_target=32'h00000046 gives npc=32'h00000044, and misalign_err=1 until the next rst pulse.

Source files
------------

// File: rtl/npc_gen_pkg.sv
// Shared fetch-stage definitions: address width, reset/step defaults and
// the redirect source encoding seen by the hazard unit and trace monitors.
package npc_gen_pkg;

  localparam int          ADDR_W           = 32;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam int          DEF_PC_STEP      = 4;

  typedef enum logic [1:0] {
    SRC_NONE   = 2'd0,
    SRC_BRANCH = 2'd1,
    SRC_JUMP   = 2'd2
  } redirect_src_e;

  // Instructions are word aligned; the low two target bits are never used.
  function automatic logic [ADDR_W-1:0] align_target(input logic [ADDR_W-1:0] t);
    return {t[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/npc_redirect_hold.sv
// Redirect arbitration (branch over jump) and the single-entry hold register
// that parks a redirect arriving during a stall until the stall clears.
module npc_redirect_hold
  import npc_gen_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  output logic              pend_valid,
  output logic [ADDR_W-1:0] pend_target,
  output logic              new_valid,
  output logic [ADDR_W-1:0] new_target,
  output logic              accept_misaligned
);

  redirect_src_e     sel_src;
  logic [ADDR_W-1:0] sel_raw;
  logic              capture;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; that is what keeps synthesis from inferring a latch.
  always_comb begin
    sel_src = SRC_NONE;
    sel_raw = '0;
    if (br_taken) begin
      sel_src = SRC_BRANCH;
      sel_raw = br_target;
    end else if (jump) begin
      sel_src = SRC_JUMP;
      sel_raw = jump_target;
    end
  end

  // A stalled branch always overwrites the hold entry (it is older); a stalled
  // jump only fills an empty one.
  assign capture = stall && ((sel_src == SRC_BRANCH) ||
                             (sel_src == SRC_JUMP && !pend_valid));

  // A held redirect outranks a fresh one, which is on the squashed path.
  assign new_valid  = !stall && !pend_valid && (sel_src != SRC_NONE);
  assign new_target = align_target(sel_raw);

  assign accept_misaligned = (capture || new_valid) && (sel_raw[1:0] != 2'b00);

  // NOTE: state updates use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid  <= 1'b0;
      pend_target <= '0;
    end else if (capture) begin
      pend_valid  <= 1'b1;
      pend_target <= new_target;
    end else if (!stall && pend_valid) begin
      pend_valid  <= 1'b0;
    end
  end

endmodule

// File: rtl/npc_gen.sv
// Next-PC generator: sequential step, branch/jump redirects, stall hold,
// IF/ID flush shadow and fetch-valid qualification.
module npc_gen
  import npc_gen_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter int          PC_STEP      = DEF_PC_STEP,
  parameter int          FLUSH_SLOTS  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] npc,
  output logic        fetch_valid,
  output logic        flush_if_id,
  output logic        redirect_pending,
  output logic        misalign_err
);

  localparam int CNT_W = $clog2(FLUSH_SLOTS + 1);

  logic              pend_valid;
  logic [ADDR_W-1:0] pend_target;
  logic              new_valid;
  logic [ADDR_W-1:0] new_target;
  logic              accept_misaligned;
  logic              applied;
  logic [CNT_W-1:0]  flush_cnt;

  npc_redirect_hold u_hold (
    .clk               (clk),
    .rst               (rst),
    .stall             (stall),
    .br_taken          (br_taken),
    .br_target         (br_target),
    .jump              (jump),
    .jump_target       (jump_target),
    .pend_valid        (pend_valid),
    .pend_target       (pend_target),
    .new_valid         (new_valid),
    .new_target        (new_target),
    .accept_misaligned (accept_misaligned)
  );

  assign applied = !rst && !stall && (pend_valid || new_valid);

  always_comb begin
    npc = pc + ADDR_W'(PC_STEP);
    if (rst)             npc = RESET_VECTOR;
    else if (stall)      npc = pc;
    else if (pend_valid) npc = pend_target;
    else if (new_valid)  npc = new_target;
  end

  // flush_cnt counts the unstalled cycles still owed a flush after a redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_cnt    <= '0;
      misalign_err <= 1'b0;
    end else begin
      if (applied)
        flush_cnt <= CNT_W'(FLUSH_SLOTS);
      else if (!stall && flush_cnt != '0)
        flush_cnt <= flush_cnt - 1'b1;
      if (accept_misaligned)
        misalign_err <= 1'b1;
    end
  end

  assign redirect_pending = pend_valid;
  assign flush_if_id      = !rst && ((flush_cnt != '0) || applied);
  assign fetch_valid      = !rst && !stall && !flush_if_id;

endmodule

// File: tb/tb_npc_gen.sv
// Directed and randomized checks of npc_gen against a cycle-level model of the
// fetch redirect rules, with the PC register modelled in the bench.
module tb_npc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        stall, br_taken, jump;
  logic [31:0] br_target, jump_target;
  logic [31:0] npc;
  logic        fetch_valid, flush_if_id, redirect_pending, misalign_err;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  bit          m_pend;
  logic [31:0] m_pend_t;
  int          m_flush;
  bit          m_mis;
  logic [31:0] e_npc;
  bit          e_fv, e_fl, e_rp, e_mis;

  npc_gen dut (
    .clk              (clk),
    .rst              (rst),
    .pc               (pc),
    .stall            (stall),
    .br_taken         (br_taken),
    .br_target        (br_target),
    .jump             (jump),
    .jump_target      (jump_target),
    .npc              (npc),
    .fetch_valid      (fetch_valid),
    .flush_if_id      (flush_if_id),
    .redirect_pending (redirect_pending),
    .misalign_err     (misalign_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] t);
    return t & 32'hFFFF_FFFC;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_eval();
    bit applied;
    applied = 0;
    if (rst) begin
      e_npc = 32'h0; e_fv = 0; e_fl = 0; e_rp = 0; e_mis = 0;
    end else begin
      if (stall)         e_npc = pc;
      else if (m_pend)   begin e_npc = m_pend_t;           applied = 1; end
      else if (br_taken) begin e_npc = word_of(br_target);   applied = 1; end
      else if (jump)     begin e_npc = word_of(jump_target); applied = 1; end
      else               e_npc = 32'((64'(pc) + 64'd4) % 64'h1_0000_0000);
      e_fl  = applied || (m_flush > 0);
      e_fv  = !stall && !e_fl;
      e_rp  = m_pend;
      e_mis = m_mis;
    end
  endtask

  task automatic model_update();
    if (rst) begin
      m_pend = 0; m_pend_t = 0; m_flush = 0; m_mis = 0;
    end else if (stall) begin
      if (br_taken) begin
        m_pend = 1; m_pend_t = word_of(br_target);
        if (br_target % 4 != 0) m_mis = 1;
      end else if (jump && !m_pend) begin
        m_pend = 1; m_pend_t = word_of(jump_target);
        if (jump_target % 4 != 0) m_mis = 1;
      end
    end else if (m_pend) begin
      m_pend = 0; m_flush = 2;
    end else if (br_taken) begin
      m_flush = 2;
      if (br_target % 4 != 0) m_mis = 1;
    end else if (jump) begin
      m_flush = 2;
      if (jump_target % 4 != 0) m_mis = 1;
    end else if (m_flush > 0) begin
      m_flush--;
    end
  endtask

  // Sample away from the rising edge and compare every output with the model.
  task automatic settle();
    @(negedge clk);
    model_eval();
    check("npc", npc, e_npc);
    check("fetch_valid", 32'(fetch_valid), 32'(e_fv));
    check("flush_if_id", 32'(flush_if_id), 32'(e_fl));
    check("redirect_pending", 32'(redirect_pending), 32'(e_rp));
    check("misalign_err", 32'(misalign_err), 32'(e_mis));
  endtask

  // Clock edge: the modelled PC register loads npc, the model advances.
  task automatic tick();
    @(posedge clk);
    #1;
    model_update();
    pc = e_npc;
  endtask

  task automatic drive(input bit s, input bit b, input logic [31:0] bt,
                       input bit j, input logic [31:0] jt);
    stall = s; br_taken = b; br_target = bt; jump = j; jump_target = jt;
  endtask

  initial begin
    rst = 1'b1; pc = 32'hDEAD_BEEF;
    drive(0, 0, 32'h0, 0, 32'h0);
    m_pend = 0; m_pend_t = 0; m_flush = 0; m_mis = 0;

    // Reset state
    settle();
    check("rst_npc", npc, 32'h0000_0000);
    check("rst_fetch_valid", 32'(fetch_valid), 32'd0);
    tick();
    rst = 1'b0;

    // Sequential fetch 0,4,8 then a taken branch at 0xC
    for (int i = 0; i < 3; i++) begin
      settle();
      check("seq_pc_fv", 32'(fetch_valid), 32'd1);
      tick();
    end
    check("seq_pc_reached_c", pc, 32'h0000_000C);
    drive(0, 1, 32'h0000_0040, 0, 32'h0);
    settle();
    check("branch_npc", npc, 32'h0000_0040);
    check("branch_flush0", 32'(flush_if_id), 32'd1);
    tick();
    drive(0, 0, 32'h0, 0, 32'h0);
    settle(); check("branch_flush1", 32'(flush_if_id), 32'd1); tick();
    settle(); check("branch_flush2", 32'(flush_if_id), 32'd1); tick();
    settle(); check("branch_flush_done", 32'(flush_if_id), 32'd0); tick();

    // Simultaneous branch and jump: branch wins
    drive(0, 1, 32'h0000_0080, 1, 32'h0000_0100);
    settle(); check("br_beats_jump", npc, 32'h0000_0080); tick();
    drive(0, 0, 32'h0, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin settle(); tick(); end

    // Jump captured during a 3-cycle stall
    drive(1, 0, 32'h0, 1, 32'h0000_0200);
    settle(); check("stall_hold", npc, pc); tick();
    drive(1, 0, 32'h0, 0, 32'h0);
    settle(); check("pending_set", 32'(redirect_pending), 32'd1); tick();
    settle(); tick();
    drive(0, 0, 32'h0, 0, 32'h0);
    settle(); check("pending_applied", npc, 32'h0000_0200); tick();
    settle(); check("pending_cleared", 32'(redirect_pending), 32'd0); tick();

    // Stalled jump pending, later stalled branch overwrites it
    drive(1, 0, 32'h0, 1, 32'h0000_0300);
    settle(); tick();
    drive(1, 1, 32'h0000_0400, 0, 32'h0);
    settle(); tick();
    drive(0, 0, 32'h0, 0, 32'h0);
    settle(); check("branch_overwrites", npc, 32'h0000_0400); tick();

    // Address wrap
    pc = 32'hFFFF_FFFC;
    settle(); check("wrap", npc, 32'h0000_0000); tick();

    // Misaligned target is word-aligned and sets the sticky error
    drive(0, 1, 32'h0000_0046, 0, 32'h0);
    settle(); check("misalign_npc", npc, 32'h0000_0044); tick();
    drive(0, 0, 32'h0, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      settle(); check("misalign_sticky", 32'(misalign_err), 32'd1); tick();
    end

    // Asynchronous reset with a redirect pending
    drive(1, 0, 32'h0, 1, 32'h0000_0500);
    settle(); tick();
    rst = 1'b1;
    #1;
    check("async_rst_pending", 32'(redirect_pending), 32'd0);
    check("async_rst_misalign", 32'(misalign_err), 32'd0);
    check("async_rst_npc", npc, 32'h0000_0000);
    settle(); tick();
    rst = 1'b0;
    drive(0, 0, 32'h0, 0, 32'h0);
    settle(); check("restart_npc", npc, 32'h0000_0004); tick();

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      rst         = ($urandom_range(0, 79) == 0);
      stall       = ($urandom_range(0, 3) == 0);
      br_taken    = ($urandom_range(0, 7) == 0);
      jump        = ($urandom_range(0, 7) == 0);
      br_target   = $urandom();
      jump_target = $urandom();
      if ($urandom_range(0, 3) != 0) br_target   = br_target & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) != 0) jump_target = jump_target & 32'hFFFF_FFFC;
      if ($urandom_range(0, 15) == 0) pc = 32'hFFFF_FFFC;
      settle();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
